// File: rtl/ps2_pkg.sv
// Shared PS/2 Set-2 constants, FSM state and colour-select types.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;

  localparam logic [7:0] KEY_F     = 8'h2B;
  localparam logic [7:0] KEY_Q     = 8'h15;
  localparam logic [7:0] KEY_H     = 8'h33;
  localparam logic [7:0] KEY_X     = 8'h22;
  localparam logic [7:0] KEY_RED   = 8'h2D;
  localparam logic [7:0] KEY_GREEN = 8'h34;
  localparam logic [7:0] KEY_BLUE  = 8'h32;
  localparam logic [7:0] KEY_BLACK = 8'h44;
  localparam logic [7:0] KEY_WHITE = 8'h23;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EBRK} prefix_state_t;
  typedef enum logic [1:0] {RED, GREEN, BLUE} color_sel_t;

  // Returns {hit, glyph_index} for a non-extended scancode.
  function automatic logic [2:0] glyph_lookup(input logic [7:0] code);
    case (code)
      KEY_F:   glyph_lookup = 3'b1_00;
      KEY_Q:   glyph_lookup = 3'b1_01;
      KEY_H:   glyph_lookup = 3'b1_10;
      KEY_X:   glyph_lookup = 3'b1_11;
      default: glyph_lookup = 3'b0_00;
    endcase
  endfunction

endpackage

// File: rtl/ps2_prefix_fsm.sv
// Tracks E0/F0 prefix sequences with a per-byte timeout and flags
// completed make/break codes.
module ps2_prefix_fsm
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT = 2500000
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       code_valid,
  input  logic [7:0] scancode,
  output logic       decode_event,
  output logic       decode_release,
  output logic       decode_ext,
  output logic       key_event,
  output logic       key_release,
  output logic       key_ext
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  prefix_state_t    state, state_next;
  logic [CNT_W-1:0] count, count_next;

  // State, timeout counter and registered event outputs.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      key_event   <= 1'b0;
      key_release <= 1'b0;
      key_ext     <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      key_event   <= decode_event;
      key_release <= decode_release;
      key_ext     <= decode_ext;
    end
  end

  // Next-state decode; a decoded byte always wins over the timeout.
  always_comb begin
    state_next     = state;
    decode_event   = 1'b0;
    decode_release = 1'b0;
    decode_ext     = 1'b0;
    if (code_valid) begin
      case (state)
        IDLE: begin
          if (scancode == PS2_EXT)      state_next = EXT;
          else if (scancode == PS2_BRK) state_next = BRK;
          else                          decode_event = 1'b1;
        end
        EXT: begin
          if (scancode == PS2_BRK)      state_next = EBRK;
          else if (scancode != PS2_EXT) begin
            decode_event = 1'b1;
            decode_ext   = 1'b1;
            state_next   = IDLE;
          end
        end
        BRK: begin
          if (scancode == PS2_EXT)      state_next = EXT;
          else if (scancode != PS2_BRK) begin
            decode_event   = 1'b1;
            decode_release = 1'b1;
            state_next     = IDLE;
          end
        end
        default: begin
          if (scancode != PS2_EXT && scancode != PS2_BRK) begin
            decode_event   = 1'b1;
            decode_release = 1'b1;
            decode_ext     = 1'b1;
            state_next     = IDLE;
          end
        end
      endcase
    end else if (state != IDLE && count == CNT_LAST) begin
      state_next = IDLE;
    end
  end

  // Counter runs only while waiting inside a prefix state.
  always_comb begin
    if (code_valid || state == IDLE || count == CNT_LAST) count_next = '0;
    else                                                  count_next = count + CNT_W'(1);
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Scancode decoder: prefix FSM plus glyph-select and colour registers.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned ROWS_LOG2 = 4,
  parameter int unsigned COLOR_W   = 4,
  parameter int unsigned TIMEOUT   = 2500000
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic               code_valid,
  input  logic [7:0]         scancode,
  output logic [ADDR_W-1:0]  char_addr,
  output logic               char_enable,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b,
  output logic               key_event,
  output logic               key_release,
  output logic               key_ext
);

  localparam logic [COLOR_W-1:0] MAX = '1;

  logic       decode_event, decode_release, decode_ext;
  logic [2:0] glyph;
  logic [1:0] shown_glyph;
  color_sel_t sel;
  logic       is_make, is_break;

  ps2_prefix_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
    .vga_clk        (vga_clk),
    .reset          (reset),
    .code_valid     (code_valid),
    .scancode       (scancode),
    .decode_event   (decode_event),
    .decode_release (decode_release),
    .decode_ext     (decode_ext),
    .key_event      (key_event),
    .key_release    (key_release),
    .key_ext        (key_ext)
  );

  assign glyph    = glyph_lookup(scancode);
  assign is_make  = decode_event && !decode_release;
  assign is_break = decode_event && decode_release;

  // Glyph select with held-key semantics: only the shown key's break blanks it.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      char_addr   <= '0;
      char_enable <= 1'b0;
      shown_glyph <= '0;
    end else if (!decode_ext && glyph[2]) begin
      if (is_make) begin
        char_addr   <= ADDR_W'(glyph[1:0]) << ROWS_LOG2;
        char_enable <= 1'b1;
        shown_glyph <= glyph[1:0];
      end else if (is_break && glyph[1:0] == shown_glyph) begin
        char_enable <= 1'b0;
      end
    end
  end

  // Colour presets on plain makes, brightness stepping on extended makes.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r   <= '0;
      g   <= '0;
      b   <= '0;
      sel <= RED;
    end else if (is_make && !decode_ext) begin
      case (scancode)
        KEY_RED:   begin r <= MAX; g <= '0;  b <= '0;  sel <= RED;   end
        KEY_GREEN: begin r <= '0;  g <= MAX; b <= '0;  sel <= GREEN; end
        KEY_BLUE:  begin r <= '0;  g <= '0;  b <= MAX; sel <= BLUE;  end
        KEY_BLACK: begin r <= '0;  g <= '0;  b <= '0;  end
        KEY_WHITE: begin r <= MAX; g <= MAX; b <= MAX; end
        default: ;
      endcase
    end else if (is_make && decode_ext) begin
      if (scancode == KEY_UP) begin
        case (sel)
          RED:     if (r != MAX) r <= r + COLOR_W'(1);
          GREEN:   if (g != MAX) g <= g + COLOR_W'(1);
          default: if (b != MAX) b <= b + COLOR_W'(1);
        endcase
      end else if (scancode == KEY_DOWN) begin
        case (sel)
          RED:     if (r != '0) r <= r - COLOR_W'(1);
          GREEN:   if (g != '0) g <= g - COLOR_W'(1);
          default: if (b != '0) b <= b - COLOR_W'(1);
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder with a short prefix timeout.
module tb_ps2_key_decoder;

  logic       vga_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       code_valid = 1'b0;
  logic [7:0] scancode   = '0;
  logic [5:0] char_addr;
  logic       char_enable;
  logic [3:0] r, g, b;
  logic       key_event, key_release, key_ext;

  typedef struct {
    logic       rel;
    logic       ext;
    logic [5:0] addr;
    logic       en;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;

  ps2_key_decoder #(
    .ADDR_W(6), .ROWS_LOG2(4), .COLOR_W(4), .TIMEOUT(8)
  ) dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .code_valid  (code_valid),
    .scancode    (scancode),
    .char_addr   (char_addr),
    .char_enable (char_enable),
    .r           (r),
    .g           (g),
    .b           (b),
    .key_event   (key_event),
    .key_release (key_release),
    .key_ext     (key_ext)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic send(input logic [7:0] code);
    @(negedge vga_clk);
    code_valid = 1'b1;
    scancode   = code;
    @(negedge vga_clk);
    code_valid = 1'b0;
    scancode   = '0;
  endtask

  task automatic expect_ev(input logic rel, input logic ext, input logic [5:0] addr,
                           input logic en, input logic [3:0] rr, input logic [3:0] gg,
                           input logic [3:0] bb);
    exp_t e;
    e.rel = rel; e.ext = ext; e.addr = addr; e.en = en; e.r = rr; e.g = gg; e.b = bb;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " char_addr"},   32'(char_addr),   32'h0);
    chk({tag, " char_enable"}, 32'(char_enable), 32'h0);
    chk({tag, " rgb"},         32'({r, g, b}),   32'h0);
    chk({tag, " key_event"},   32'({key_event, key_release, key_ext}), 32'h0);
  endtask

  // Monitor: every key_event pops one expected record and compares it.
  initial begin
    exp_t e;
    forever begin
      @(negedge vga_clk);
      if (!reset && key_event) begin
        if (exp_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_event: got event rel=%0b ext=%0b expected none", key_release, key_ext);
        end else begin
          e = exp_q.pop_front();
          chk("ev_release",  32'(key_release), 32'(e.rel));
          chk("ev_ext",      32'(key_ext),     32'(e.ext));
          chk("char_addr",   32'(char_addr),   32'(e.addr));
          chk("char_enable", 32'(char_enable), 32'(e.en));
          chk("r",           32'(r),           32'(e.r));
          chk("g",           32'(g),           32'(e.g));
          chk("b",           32'(b),           32'(e.b));
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge vga_clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Glyph press/release
    expect_ev(0, 0, 6'h00, 1, 0, 0, 0);      send(8'h2B);
    send(8'hF0); expect_ev(1, 0, 6'h00, 0, 0, 0, 0); send(8'h2B);
    // Break of a key not on screen keeps the glyph
    expect_ev(0, 0, 6'h00, 1, 0, 0, 0);      send(8'h2B);
    expect_ev(0, 0, 6'h10, 1, 0, 0, 0);      send(8'h15);
    send(8'hF0); expect_ev(1, 0, 6'h10, 1, 0, 0, 0); send(8'h2B);
    expect_ev(0, 0, 6'h10, 1, 0, 0, 0);      send(8'h15);  // typematic

    // Red, then brightness down x3 and up x5
    expect_ev(0, 0, 6'h10, 1, 15, 0, 0);     send(8'h2D);
    for (int unsigned i = 0; i < 3; i++) begin
      send(8'hE0); expect_ev(0, 1, 6'h10, 1, 4'(14 - i), 0, 0); send(8'h72);
    end
    for (int unsigned i = 0; i < 5; i++) begin
      send(8'hE0); expect_ev(0, 1, 6'h10, 1, (i < 3) ? 4'(13 + i) : 4'd15, 0, 0); send(8'h75);
    end

    // Green and blue channels, black/white keep selection
    expect_ev(0, 0, 6'h10, 1, 0, 15, 0);     send(8'h34);
    send(8'hE0); expect_ev(0, 1, 6'h10, 1, 0, 14, 0); send(8'h72);
    expect_ev(0, 0, 6'h10, 1, 0, 0, 15);     send(8'h32);
    send(8'hE0); expect_ev(0, 1, 6'h10, 1, 0, 0, 15); send(8'h75);
    expect_ev(0, 0, 6'h10, 1, 0, 0, 0);      send(8'h44);
    send(8'hE0); expect_ev(0, 1, 6'h10, 1, 0, 0, 0);  send(8'h72);
    expect_ev(0, 0, 6'h10, 1, 15, 15, 15);   send(8'h23);
    send(8'hE0); expect_ev(0, 1, 6'h10, 1, 15, 15, 14); send(8'h72);

    // Extended break, repeated F0, extended make of a glyph code
    send(8'hE0); send(8'hF0); expect_ev(1, 1, 6'h10, 1, 15, 15, 14); send(8'h75);
    send(8'hF0); send(8'hF0); expect_ev(1, 0, 6'h10, 1, 15, 15, 14); send(8'h2B);
    send(8'hE0); send(8'hE0); expect_ev(0, 1, 6'h10, 1, 15, 15, 14); send(8'h33);
    send(8'hF0); expect_ev(1, 0, 6'h10, 0, 15, 15, 14); send(8'h15);

    // Prefix timeout: F0 then idle, next byte is a make
    send(8'hF0);
    repeat (12) @(negedge vga_clk);
    expect_ev(0, 0, 6'h20, 1, 15, 15, 14);   send(8'h33);

    // Reset in the middle of an E0 sequence
    send(8'hE0);
    #2 reset = 1'b1;
    #1 check_reset_outputs("midreset");
    @(negedge vga_clk);
    reset = 1'b0;
    expect_ev(0, 0, 6'h00, 0, 0, 0, 0);      send(8'h75);

    repeat (5) @(negedge vga_clk);
    chk("pending_events", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Parametrised successor to the single-byte scancode decoder.
- Tracks PS/2 Set-2 prefix sequences (E0 extended, F0 break) with a state machine, so key press and key release are distinct events.
- Drives the character-ROM glyph start address and enable with held-key semantics, plus per-channel multi-bit colour with brightness stepping.
- Sits between the PS/2 receiver (byte strobe) and the VGA character/colour generator, all in the vga_clk domain.

Parameters:
- ADDR_W, 6, width of char_addr; must be >= ROWS_LOG2+2.
- ROWS_LOG2, 4, log2 of rows per glyph; glyph k starts at k<<ROWS_LOG2.
- COLOR_W, 4, bits per colour channel; MAX = 2^COLOR_W-1.
- TIMEOUT, 2500000, vga_clk cycles a prefix state may wait for the next byte (100 ms at 25 MHz).

Ports:
- vga_clk  in  1  pixel clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high.
- code_valid  in  1  one-cycle strobe; scancode is valid this cycle.
- scancode  in  8  received PS/2 byte.
- char_addr  out  ADDR_W  glyph start address in the character ROM.
- char_enable  out  1  glyph display enable.
- r, g, b  out  COLOR_W each  colour channel levels.
- key_event  out  1  one-cycle pulse when a complete make or break has been decoded.
- key_release  out  1  valid with key_event: 1 = break, 0 = make.
- key_ext  out  1  valid with key_event: 1 = E0-prefixed key.

Behaviour:
- Reset (async) values: state=IDLE, char_addr=0, char_enable=0, r=g=b=0, sel=RED, key_event=0, key_release=0, key_ext=0, timeout counter=0.
- All outputs are registered. Effects appear on the first edge after the code_valid cycle of the final byte, so latency is 1 cycle.
- Prefix FSM, evaluated only when code_valid=1:
  - IDLE: E0 goes to EXT. F0 goes to BRK. Any other byte is a make with ext=0, and the state stays IDLE.
  - EXT: F0 goes to EBRK. E0 stays in EXT. Any other byte is a make with ext=1, then IDLE.
  - BRK: E0 goes to EXT (a malformed sequence is resynchronised). F0 stays in BRK. Any other byte is a break with ext=0, then IDLE.
  - EBRK: E0 or F0 stays in EBRK. Any other byte is a break with ext=1, then IDLE.
- Timeout:
  - The counter runs while in EXT, BRK or EBRK.
  - It clears on every code_valid and whenever the state is IDLE.
  - On reaching TIMEOUT-1 the FSM returns to IDLE with no event, so the next byte decodes as a plain code.
- key_event pulses for exactly one cycle per decoded make or break. It never pulses for prefix bytes.
- Glyph map (non-extended codes only), glyph index k:
  - 2B (F) is k=0, 15 (Q) is k=1, 33 (H) is k=2, 22 (X) is k=3.
  - A make of a glyph key sets char_addr = k<<ROWS_LOG2 (zero-extended to ADDR_W) and sets char_enable=1.
  - A break of the glyph key currently displayed clears char_enable; char_addr holds.
  - A break of any other key leaves the glyph outputs unchanged.
  - A repeated make (typematic) of the same key leaves the outputs unchanged.
- Colour map (makes only, non-extended):
  - 2D sets r=MAX, g=b=0, sel=RED.
  - 34 sets g=MAX, r=b=0, sel=GREEN.
  - 32 sets b=MAX, r=g=0, sel=BLUE.
  - 44 sets r=g=b=0.
  - 23 sets r=g=b=MAX.
  - The 44 and 23 keys leave sel unchanged.
- Brightness (extended makes only):
  - E0 75 (up) increments the sel channel, saturating at MAX.
  - E0 72 (down) decrements the sel channel, saturating at 0.
- Breaks never change colour. Unmapped makes and breaks produce key_event only.
- No more than one event can occur per cycle, so there are no simultaneous-update cases.
- Reset asserted mid-sequence discards any pending prefix.

Decomposition:
- Shared package ps2_pkg holds:
  - constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0;
  - the key-code constants listed above;
  - an FSM state enum {IDLE, EXT, BRK, EBRK};
  - a colour-select enum {RED, GREEN, BLUE}.
- One natural sub-module: ps2_prefix_fsm (FSM plus timeout counter, emitting key_event, key_release, key_ext and the code). The top level holds the glyph and colour registers.

Test Plan:
- Reset, then 2B: char_addr=0x00, char_enable=1, key_event pulses with release=0, ext=0. Then F0, 2B: char_enable=0 and key_event pulses with release=1.
- 2B, then 15, then F0 2B: char_addr=0x10 and char_enable stays 1, because the released key is not the displayed key.
- 2D, then E0 72 sent 3 times: r goes 15, 14, 13, 12. Then E0 75 sent 5 times: r saturates at 15, with g=b=0.
- E0 F0 75 (extended break): key_event with release=1, ext=1, and r/g/b unchanged. Bytes F0 F0 2B: a single break event.
- F0, then idle for TIMEOUT cycles (use TIMEOUT=8 in the bench), then 33: decoded as a make, so char_addr=0x20 and char_enable=1.
- Send E0, assert reset, then 75: no brightness change. All outputs read their reset values immediately after reset asserts.
